// File: rtl/spi_master_initiator_if.sv
// rtl/spi_master_initiator_if.sv - host request bus and SPI pins of the SPI initiator
interface spi_master_initiator_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       verify_err;
  logic       sclk_pin;
  logic       cs_pin;
  logic       mosi_pin;
  logic       miso_pin;

  // Host and peripheral side: issues requests, drives MISO, observes everything else.
  modport master (
    output start, rw, addr, wdata, miso_pin,
    input  busy, done, rdata, verify_err, sclk_pin, cs_pin, mosi_pin
  );

  // Initiator side.
  modport slave (
    input  start, rw, addr, wdata, miso_pin,
    output busy, done, rdata, verify_err, sclk_pin, cs_pin, mosi_pin
  );
endinterface

// File: rtl/spi_master_initiator.sv
// rtl/spi_master_initiator.sv - SPI mode-0 initiator, one 16-bit {addr,rw,data} frame per request
// Optional automatic write readback/verify: define SPI_MASTER_READBACK_EN.
module spi_master_initiator #(
  parameter int SCLK_HALF = 16,
  parameter int CS_SETUP  = 8,
  parameter int CS_HOLD   = 8,
  parameter int CS_GAP    = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  spi_master_initiator_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] HALF_LAST  = 8'(SCLK_HALF - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic        phase_q, phase_d;    // 0 = SCLK low half, 1 = SCLK high half
  logic [15:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic        rw_q, rw_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        sclk_q, sclk_d;
  logic        cs_q, cs_d;
  logic        mosi_q, mosi_d;
  logic [1:0]  miso_sync;
`ifdef SPI_MASTER_READBACK_EN
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rb_q, rb_d;          // current frame is the automatic readback of a write
  logic        verr_q, verr_d;
`endif

  // Two-stage synchroniser for the asynchronous MISO pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) miso_sync <= 2'b00;
    else        miso_sync <= {miso_sync[0], bus.miso_pin};
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rw_d    = rw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
`ifdef SPI_MASTER_READBACK_EN
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rb_d    = rb_q;
    verr_d  = verr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rw_d    = bus.rw;
          tx_d    = {bus.addr, bus.rw, (bus.rw ? 8'h00 : bus.wdata)};
          mosi_d  = bus.addr[6];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
          bit_d   = 4'd0;
          phase_d = 1'b0;
          state_d = SETUP;
`ifdef SPI_MASTER_READBACK_EN
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          rb_d    = 1'b0;
`endif
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = 8'd0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SHIFT: begin
        if (cnt_q != HALF_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
            // Bits 8..15 carry the peripheral's read data.
            if (bit_q[3]) rx_d = {rx_q[6:0], miso_sync[1]};
          end else begin
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (bit_q == 4'd15) begin
              mosi_d  = 1'b0;
              state_d = HOLD;
            end else begin
              bit_d  = bit_q + 4'd1;
              tx_d   = tx_q << 1;
              mosi_d = tx_d[15];
            end
          end
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = 8'd0;
          cs_d    = 1'b1;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = 8'd0;
`ifdef SPI_MASTER_READBACK_EN
          if (!rw_q) begin
            // Write finished: chain a read of the same address without returning to IDLE.
            rw_d    = 1'b1;
            rb_d    = 1'b1;
            tx_d    = {addr_q, 1'b1, 8'h00};
            mosi_d  = addr_q[6];
            cs_d    = 1'b0;
            bit_d   = 4'd0;
            phase_d = 1'b0;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            rdata_d = rx_q;
            if (rb_q) begin
              verr_d = (rx_q != wdata_q);
              rb_d   = 1'b0;
            end
          end
`else
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (rw_q) rdata_d = rx_q;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered-output flops; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 4'd0;
      phase_q <= 1'b0;
      tx_q    <= 16'd0;
      rx_q    <= 8'd0;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 8'd0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
`ifdef SPI_MASTER_READBACK_EN
      addr_q  <= 7'd0;
      wdata_q <= 8'd0;
      rb_q    <= 1'b0;
      verr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
`ifdef SPI_MASTER_READBACK_EN
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rb_q    <= rb_d;
      verr_q  <= verr_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.sclk_pin = sclk_q;
  assign bus.cs_pin   = cs_q;
  assign bus.mosi_pin = mosi_q;
`ifdef SPI_MASTER_READBACK_EN
  assign bus.verify_err = verr_q;
`else
  assign bus.verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_initiator.sv
// tb/tb_spi_master_initiator.sv - directed bench for spi_master_initiator with a SPI memory model
module tb_spi_master_initiator;

`ifdef SPI_MASTER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_master_initiator_if bus();
  spi_master_initiator dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_pass;
  int n_total;

  // Peripheral model: shifts MOSI on SCLK rises, drives read data on SCLK falls.
  logic [7:0]  mem [128];
  logic [15:0] sp_sh;
  int          sp_cnt;
  logic [7:0]  sp_rd;
  logic        fault;
  int          rise_total;
  logic [15:0] frame_log [256];
  int          frame_n;

  always @(posedge bus.sclk_pin or posedge bus.cs_pin) begin
    if (bus.cs_pin) begin
      sp_cnt = 0;
    end else begin
      rise_total++;
      sp_sh = {sp_sh[14:0], bus.mosi_pin};
      sp_cnt++;
      if (sp_cnt == 16) begin
        frame_log[frame_n[7:0]] = sp_sh;
        frame_n++;
        if (!sp_sh[8]) mem[sp_sh[15:9]] = sp_sh[7:0];
      end
    end
  end

  always @(negedge bus.sclk_pin) begin
    if (!bus.cs_pin && sp_cnt >= 8 && sp_cnt < 16) begin
      if (sp_cnt == 8) begin
        sp_rd = mem[sp_sh[7:1]];
        if (fault) sp_rd[2] = 1'b0;
      end
      bus.miso_pin = sp_rd[15 - sp_cnt];
    end
  end

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] exp_mosi;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_frame(input logic r, input logic [6:0] a, input logic [7:0] d,
                           output int cyc, output int cs_low, output logic busy1, output bit ok);
    bus.rw = r; bus.addr = a; bus.wdata = d; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy1 = bus.busy;
    cyc = 1; cs_low = 0; ok = 1'b0;
    while (cyc < 3000) begin
      if (!bus.cs_pin) cs_low++;
      if (bus.done) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic count_dones(input int n_cyc, output int n_done);
    n_done = 0;
    for (int k = 0; k < n_cyc; k++) begin
      @(posedge clk); #1;
      if (bus.done) n_done++;
    end
  endtask

  initial begin
    int cyc, csl, f0, r0, frames, nd, hi;
    logic b1;
    bit ok;
    logic [7:0] saved, exp_rd;

    vecs[0] = '{1'b0, 7'h00, 8'hCC, 16'h00CC, 8'h00};
    vecs[1] = '{1'b0, 7'h01, 8'hA5, 16'h02A5, 8'h00};
    vecs[2] = '{1'b1, 7'h01, 8'h00, 16'h0300, 8'hA5};
    vecs[3] = '{1'b1, 7'h00, 8'h77, 16'h0100, 8'hCC};
    vecs[4] = '{1'b0, 7'h7F, 8'h5A, 16'hFE5A, 8'hCC};
    vecs[5] = '{1'b1, 7'h7F, 8'h00, 16'hFF00, 8'h5A};

    n_pass = 0; n_total = 0;
    bus.start = 1'b0; bus.rw = 1'b0; bus.addr = 7'h00; bus.wdata = 8'h00;
    fault = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // {cs, sclk, mosi, busy, done, verify_err, rdata}
    check("reset_state", {bus.cs_pin, bus.sclk_pin, bus.mosi_pin, bus.busy, bus.done,
                          bus.verify_err, bus.rdata}, {6'b100000, 8'h00});
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      f0 = frame_n; r0 = rise_total;
      run_frame(vecs[i].rw, vecs[i].addr, vecs[i].wdata, cyc, csl, b1, ok);
      frames = (RB && !vecs[i].rw) ? 2 : 1;
      exp_rd = (RB && !vecs[i].rw) ? vecs[i].wdata : vecs[i].exp_rdata;
      check($sformatf("v%0d_done_seen", i), 32'(ok), 32'd1);
      check($sformatf("v%0d_cycles", i), cyc, (frames == 2) ? 1089 : 545);
      check($sformatf("v%0d_busy_first", i), b1, 1'b1);
      check($sformatf("v%0d_busy_at_done", i), bus.busy, 1'b0);
      check($sformatf("v%0d_cs_low_cycles", i), csl, 528 * frames);
      check($sformatf("v%0d_sclk_rises", i), rise_total - r0, 16 * frames);
      check($sformatf("v%0d_mosi_frame", i), frame_log[f0[7:0]], vecs[i].exp_mosi);
      check($sformatf("v%0d_rdata", i), bus.rdata, exp_rd);
      check($sformatf("v%0d_verify_err", i), bus.verify_err, 1'b0);
      if (!vecs[i].rw)
        check($sformatf("v%0d_mem", i), mem[vecs[i].addr], vecs[i].wdata);
    end

    // Second start mid-SHIFT and input changes after acceptance are ignored.
    f0 = frame_n; r0 = rise_total; saved = mem[7'h22];
    bus.rw = 1'b0; bus.addr = 7'h10; bus.wdata = 8'h11; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.rw = 1'b1; bus.addr = 7'h22; bus.wdata = 8'h33;
    repeat (100) @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    count_dones(1800, nd);
    check("ignore_done_count", nd, 1);
    check("ignore_sclk_rises", rise_total - r0, RB ? 32 : 16);
    check("ignore_mosi_frame", frame_log[f0[7:0]], 16'h2011);
    check("ignore_mem_target", mem[7'h10], 8'h11);
    check("ignore_mem_other", mem[7'h22], saved);

    // Reset during bit 5 of SHIFT.
    f0 = frame_n; r0 = rise_total; saved = mem[7'h30];
    bus.rw = 1'b0; bus.addr = 7'h30; bus.wdata = 8'h77; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    while ((rise_total - r0) < 5 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reached_bit5", 32'(cyc < 1000), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_pins_now", {bus.cs_pin, bus.sclk_pin, bus.busy, bus.done}, 4'b1000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_rdata_cleared", bus.rdata, 8'h00);
    count_dones(600, nd);
    check("abort_no_done", nd, 0);
    check("abort_no_frame", frame_n - f0, 0);
    check("abort_mem_untouched", mem[7'h30], saved);
    f0 = frame_n; r0 = rise_total;
    run_frame(1'b1, 7'h00, 8'h00, cyc, csl, b1, ok);
    check("after_abort_done_seen", 32'(ok), 32'd1);
    check("after_abort_cycles", cyc, 545);
    check("after_abort_rises", rise_total - r0, 16);
    check("after_abort_mosi", frame_log[f0[7:0]], 16'h0100);
    check("after_abort_rdata", bus.rdata, 8'hCC);

    // Back-to-back: start held high through the done cycle.
    bus.rw = 1'b1; bus.addr = 7'h01; bus.wdata = 8'hFF; bus.start = 1'b1;
    @(posedge clk); #1;
    cyc = 1; hi = 0; ok = 1'b0;
    while (cyc < 3000) begin
      if (bus.cs_pin) hi++; else hi = 0;
      if (bus.done) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_first_done", 32'(ok), 32'd1);
    check("b2b_first_cycles", cyc, 545);
    check("b2b_busy_at_done", bus.busy, 1'b0);
    check("b2b_cs_high_run", hi, 17);
    @(posedge clk); #1;
    check("b2b_restart", {bus.busy, bus.cs_pin}, 2'b10);
    bus.start = 1'b0;
    cyc = 1; ok = 1'b0;
    while (cyc < 3000) begin
      if (bus.done) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_second_done", 32'(ok), 32'd1);
    check("b2b_second_cycles", cyc, 545);
    check("b2b_second_rdata", bus.rdata, 8'hA5);

`ifdef SPI_MASTER_READBACK_EN
    // Readback with a stuck-low bit 2 in the peripheral, then fault-free.
    fault = 1'b1;
    r0 = rise_total;
    run_frame(1'b0, 7'h05, 8'h3C, cyc, csl, b1, ok);
    check("rb_fault_done", 32'(ok), 32'd1);
    check("rb_fault_cycles", cyc, 1089);
    check("rb_fault_rises", rise_total - r0, 32);
    check("rb_fault_rdata", bus.rdata, 8'h38);
    check("rb_fault_verify_err", bus.verify_err, 1'b1);
    fault = 1'b0;
    run_frame(1'b0, 7'h05, 8'h3C, cyc, csl, b1, ok);
    check("rb_clean_done", 32'(ok), 32'd1);
    check("rb_clean_rdata", bus.rdata, 8'h3C);
    check("rb_clean_verify_err", bus.verify_err, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
